// File: rtl/alu_ctrl_issue.sv
// EX-stage ALU issue control: decodes ALUOp/funct to a 3-bit op code,
// registers it, and sequences multi-cycle MUL with a pipeline stall.
module alu_ctrl_issue #(
  parameter int MUL_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       valid_i,
  input  logic [1:0] ALUOp_i,
  input  logic [5:0] funct_i,
  output logic [2:0] ALUCtrl_o,
  output logic       valid_o,
  output logic       stall_o,
  output logic       illegal_o
);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);
  localparam bit         MUL_MC = (MUL_CYCLES > 1);

  state_t     r_state;
  state_t     w_state;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt;
  logic [2:0] r_ctrl;
  logic [2:0] w_ctrl;
  logic       r_valid;
  logic       w_valid;
  logic       r_stall;
  logic       w_stall;
  logic       r_ill;
  logic       w_ill;
  logic [2:0] w_code;
  logic       w_bad;

  always_comb begin
    w_code = OP_ADD;
    w_bad  = 1'b0;
    unique case (ALUOp_i)
      2'b00: w_code = OP_ADD;
      2'b01: w_code = OP_SUB;
      2'b11: w_code = OP_OR;
      2'b10: begin
        unique case (1'b1)
          (funct_i == 6'b100000): w_code = OP_ADD;
          (funct_i == 6'b100010): w_code = OP_SUB;
          (funct_i == 6'b100100): w_code = OP_AND;
          (funct_i == 6'b100101): w_code = OP_OR;
          (funct_i == 6'b011000): w_code = OP_MUL;
          default: begin
            w_code = OP_ADD;
            w_bad  = 1'b1;
          end
        endcase
      end
      default: w_code = OP_ADD;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_ctrl  = r_ctrl;
    w_valid = 1'b0;
    w_stall = 1'b0;
    w_ill   = 1'b0;
    if (flush_i) begin
      w_state = S_IDLE;
      w_cnt   = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            w_ctrl = w_code;
            w_ill  = w_bad;
            if (w_code == OP_MUL && MUL_MC) begin
              w_state = S_MUL;
              w_cnt   = CNT_INIT;
              w_stall = 1'b1;
            end else begin
              w_valid = 1'b1;
            end
          end
        end
        S_MUL: begin
          w_cnt = r_cnt - 4'd1;
          // Final count: release the stall and present the result.
          if (r_cnt == 4'd1) begin
            w_state = S_IDLE;
            w_valid = 1'b1;
          end else begin
            w_stall = 1'b1;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ctrl  <= OP_ADD;
      r_valid <= 1'b0;
      r_stall <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ctrl  <= w_ctrl;
      r_valid <= w_valid;
      r_stall <= w_stall;
      r_ill   <= w_ill;
    end
  end

  assign ALUCtrl_o = r_ctrl;
  assign valid_o   = r_valid;
  assign stall_o   = r_stall;
  assign illegal_o = r_ill;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue: one DUT with MUL_CYCLES=3,
// one with MUL_CYCLES=1, sharing the same stimulus.
module tb_alu_ctrl_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       valid;
  logic [1:0] aluop;
  logic [5:0] funct;

  logic [2:0] ctrl3;
  logic       valid3;
  logic       stall3;
  logic       ill3;
  logic [2:0] ctrl1;
  logic       valid1;
  logic       stall1;
  logic       ill1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.MUL_CYCLES(3)) dut3 (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .valid_i  (valid),
    .ALUOp_i  (aluop),
    .funct_i  (funct),
    .ALUCtrl_o(ctrl3),
    .valid_o  (valid3),
    .stall_o  (stall3),
    .illegal_o(ill3)
  );

  alu_ctrl_issue #(.MUL_CYCLES(1)) dut1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .valid_i  (valid),
    .ALUOp_i  (aluop),
    .funct_i  (funct),
    .ALUCtrl_o(ctrl1),
    .valid_o  (valid1),
    .stall_o  (stall1),
    .illegal_o(ill1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ctrl3 !== 3'b010) begin
      failures++;
      $display("FAIL reset_ctrl3 got=%b exp=010", ctrl3);
    end
    checks++;
    if ({valid3, stall3, ill3} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags3 got=%b exp=000",
               {valid3, stall3, ill3});
    end
    checks++;
    if (ctrl1 !== 3'b010) begin
      failures++;
      $display("FAIL reset_ctrl1 got=%b exp=010", ctrl1);
    end
    checks++;
    if ({valid1, stall1, ill1} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags1 got=%b exp=000",
               {valid1, stall1, ill1});
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [1:0] ops [5];
    logic [5:0] fns [5];
    logic [2:0] exp [5];
    ops = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    fns = '{6'b100100, 6'b100101, 6'b100010, 6'b000000, 6'b100100};
    exp = '{3'b000, 3'b001, 3'b011, 3'b011, 3'b001};
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      aluop = ops[i];
      funct = fns[i];
      tick();
      checks++;
      if ({ctrl3, valid3, stall3} !== {exp[i], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL stream_%0d got=%b/%b/%b exp=%b/1/0",
                 i, ctrl3, valid3, stall3, exp[i]);
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if ({ctrl3, valid3, ill3} !== {3'b001, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_hold got=%b/%b/%b exp=001/0/0",
               ctrl3, valid3, ill3);
    end
  endtask

  task automatic test_mul();
    valid = 1'b1;
    aluop = 2'b10;
    funct = 6'b011000;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({ctrl3, stall3, valid3} !== {3'b100, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL mul_busy_%0d got=%b/%b/%b exp=100/1/0",
                 c, ctrl3, stall3, valid3);
      end
    end
    tick();
    checks++;
    if ({ctrl3, stall3, valid3} !== {3'b100, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mul_done got=%b/%b/%b exp=100/0/1",
               ctrl3, stall3, valid3);
    end
    aluop = 2'b00;
    funct = 6'b000000;
    tick();
    checks++;
    if ({ctrl3, stall3, valid3} !== {3'b010, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mul_b2b_add got=%b/%b/%b exp=010/0/1",
               ctrl3, stall3, valid3);
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    valid = 1'b1;
    aluop = 2'b10;
    funct = 6'b011000;
    tick();
    checks++;
    if (stall3 !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_stall got=%b exp=1", stall3);
    end
    flush = 1'b1;
    aluop = 2'b00;
    funct = 6'b000000;
    tick();
    checks++;
    if ({ctrl3, stall3, valid3} !== {3'b100, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_next got=%b/%b/%b exp=100/0/0",
               ctrl3, stall3, valid3);
    end
    flush = 1'b0;
    valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({valid3, stall3} !== 2'b00) begin
        failures++;
        $display("FAIL flush_quiet_%0d got=%b/%b exp=0/0",
                 c, valid3, stall3);
      end
    end
  endtask

  task automatic test_illegal();
    valid = 1'b1;
    aluop = 2'b10;
    funct = 6'b111111;
    tick();
    checks++;
    if ({ctrl3, valid3, ill3} !== {3'b010, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL illegal_pulse got=%b/%b/%b exp=010/1/1",
               ctrl3, valid3, ill3);
    end
    aluop = 2'b00;
    tick();
    checks++;
    if ({ctrl3, valid3, ill3} !== {3'b010, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL illegal_funct_ignored got=%b/%b/%b exp=010/1/0",
               ctrl3, valid3, ill3);
    end
    valid = 1'b0;
    tick();
    checks++;
    if ({valid3, ill3} !== 2'b00) begin
      failures++;
      $display("FAIL illegal_clear got=%b/%b exp=0/0", valid3, ill3);
    end
  endtask

  task automatic test_mul1();
    valid = 1'b1;
    aluop = 2'b10;
    funct = 6'b011000;
    tick();
    checks++;
    if ({ctrl1, valid1, stall1} !== {3'b100, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mul1_issue got=%b/%b/%b exp=100/1/0",
               ctrl1, valid1, stall1);
    end
    aluop = 2'b01;
    funct = 6'b000000;
    tick();
    checks++;
    if ({ctrl1, valid1, stall1} !== {3'b011, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mul1_b2b got=%b/%b/%b exp=011/1/0",
               ctrl1, valid1, stall1);
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    valid = 1'b1;
    aluop = 2'b10;
    funct = 6'b011000;
    tick();
    checks++;
    if ({ctrl3, stall3} !== {3'b100, 1'b1}) begin
      failures++;
      $display("FAIL rstmul_pre got=%b/%b exp=100/1", ctrl3, stall3);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ctrl3, valid3, stall3, ill3} !== {3'b010, 3'b000}) begin
      failures++;
      $display("FAIL rstmul_reset got=%b/%b/%b/%b exp=010/0/0/0",
               ctrl3, valid3, stall3, ill3);
    end
    rst = 1'b0;
    valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({valid3, stall3} !== 2'b00) begin
        failures++;
        $display("FAIL rstmul_quiet_%0d got=%b/%b exp=0/0",
                 c, valid3, stall3);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    aluop = 2'b00;
    funct = 6'b000000;
    test_reset();
    test_stream();
    test_mul();
    test_flush();
    test_illegal();
    test_mul1();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
